// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and binary index.
// Grants are held until done, withdrawal or the hold limit expires.
module onehot_rr_arbiter #(
  parameter int WIDTH_P    = 10,
  parameter int MAX_HOLD_P = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [WIDTH_P-1:0]         req_i,
  input  logic                       done_i,
  output logic [WIDTH_P-1:0]         grant_o,
  output logic [$clog2(WIDTH_P)-1:0] grant_idx_o,
  output logic                       grant_valid_o,
  output logic                       timeout_o
);

  localparam int IDX_W = $clog2(WIDTH_P);
  localparam int CNT_W = $clog2(MAX_HOLD_P + 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   ptr_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [WIDTH_P-1:0] grant_nxt;
  logic [IDX_W-1:0]   idx_nxt;
  logic               valid_nxt;
  logic               timeout_nxt;
  logic [IDX_W-1:0]   pick;
  logic               found;
  logic               at_limit;
  logic               withdrawn;
  logic [IDX_W:0]     pos;

  // First requester at or above the pointer, wrapping modulo WIDTH_P.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < WIDTH_P; k++) begin
      pos = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (pos >= (IDX_W + 1)'(WIDTH_P)) begin
        pos = pos - (IDX_W + 1)'(WIDTH_P);
      end
      if (!found && req_i[pos[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = pos[IDX_W-1:0];
      end
    end
  end

  assign at_limit  = (cnt == CNT_W'(MAX_HOLD_P - 1));
  assign withdrawn = !req_i[grant_idx_o];

  // Next-state, next-grant and pointer update.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_o;
    idx_nxt     = grant_idx_o;
    valid_nxt   = grant_valid_o;
    timeout_nxt = 1'b0;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_nxt       = '0;
          grant_nxt[pick] = 1'b1;
          idx_nxt         = pick;
          valid_nxt       = 1'b1;
          cnt_nxt         = '0;
          state_nxt       = GRANT;
        end
      end
      GRANT: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (done_i || withdrawn || at_limit) begin
          state_nxt   = RELEASE;
          grant_nxt   = '0;
          idx_nxt     = '0;
          valid_nxt   = 1'b0;
          timeout_nxt = at_limit && !done_i && !withdrawn;
          if (grant_idx_o == IDX_W'(WIDTH_P - 1)) begin
            ptr_nxt = '0;
          end else begin
            ptr_nxt = grant_idx_o + IDX_W'(1);
          end
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      grant_o       <= '0;
      grant_idx_o   <= '0;
      grant_valid_o <= 1'b0;
      timeout_o     <= 1'b0;
      ptr           <= '0;
      cnt           <= '0;
    end else begin
      state         <= state_nxt;
      grant_o       <= grant_nxt;
      grant_idx_o   <= idx_nxt;
      grant_valid_o <= valid_nxt;
      timeout_o     <= timeout_nxt;
      ptr           <= ptr_nxt;
      cnt           <= cnt_nxt;
    end
  end

endmodule
